// File: rtl/logic_gate_unit_if.sv
// Producer/consumer bundle for logic_gate_unit: operand input side, buffered result side and the pop counter.
// The master modport is the producer/consumer side; the slave modport is the unit itself.
interface logic_gate_unit_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, y, y_all, y_any, out_valid, op_count
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, y, y_all, y_any, out_valid, op_count
  );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit logic unit: run-time selectable gate, 2-entry output FIFO with valid/ready,
// reduction flags stored alongside each result, and a wrapping count of output handshakes.
module logic_gate_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  logic_gate_unit_if.slave  bus
);

  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [EW-1:0]    r_head;
  logic [EW-1:0]    r_tail;
  logic [CNT_W-1:0] r_op_count;

  logic [WIDTH-1:0] w_res;
  logic             w_all;
  logic             w_any;
  logic [EW-1:0]    w_entry;
  logic             w_accept;
  logic             w_pop;
  logic             w_wr_head;
  logic             w_wr_tail;
  logic             w_shift;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        w_res[gi] = 1'b0;
        case (bus.op)
          3'd0:    w_res[gi] =   bus.a[gi] & bus.b[gi];
          3'd1:    w_res[gi] =   bus.a[gi] | bus.b[gi];
          3'd2:    w_res[gi] =   bus.a[gi] ^ bus.b[gi];
          3'd3:    w_res[gi] = ~(bus.a[gi] & bus.b[gi]);
          3'd4:    w_res[gi] = ~(bus.a[gi] | bus.b[gi]);
          3'd5:    w_res[gi] = ~(bus.a[gi] ^ bus.b[gi]);
          3'd6:    w_res[gi] =  ~bus.a[gi];
          default: w_res[gi] =   bus.a[gi];
        endcase
      end
    end
  endgenerate

  // Flags are computed once here and travel through the buffer with the result.
  assign w_all   = &w_res;
  assign w_any   = |w_res;
  assign w_entry = {w_res, w_all, w_any};

  // in_ready comes only from state, so a pop while FULL never admits a new entry that cycle.
  assign w_accept = bus.in_valid && (r_state != S_FULL);
  assign w_pop    = (r_state != S_EMPTY) && bus.out_ready;

  always_comb begin
    w_state_next = r_state;
    w_wr_head    = 1'b0;
    w_wr_tail    = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next = S_ONE;
          w_wr_head    = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_wr_head = 1'b1;
        end else if (w_accept) begin
          w_state_next = S_FULL;
          w_wr_tail    = 1'b1;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_next = S_ONE;
          w_shift      = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_wr_head) begin
        r_head <= w_entry;
      end else if (w_shift) begin
        r_head <= r_tail;
      end
      if (w_wr_tail) begin
        r_tail <= w_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.y         = r_head[EW-1:2];
  assign bus.y_all     = r_head[1];
  assign bus.y_any     = r_head[0];
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: expected entries queued on accept, compared on pop.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_unit_if #(.WIDTH(4), .CNT_W(8)) dif ();
  logic_gate_unit_if #(.WIDTH(4), .CNT_W(2)) wif ();

  logic_gate_unit #(.WIDTH(4), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(dif.slave));
  logic_gate_unit #(.WIDTH(4), .CNT_W(2)) u_wrap (.clk(clk), .rst(rst), .bus(wif.slave));

  int         n_vec = 0;
  int         n_bad = 0;
  logic [5:0] sb[$];
  logic [5:0] cur_exp = '0;
  logic [7:0] exp_count = '0;
  logic       stream_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] gate_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    return {r, &r, |r};
  endfunction

  // Scoreboard monitor: decides at the negedge what the following rising edge will do.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst) begin
      sb.delete();
      exp_count = '0;
    end else begin
      chk("op_count", 32'(dif.op_count), 32'(exp_count));
      if (stream_chk) begin
        chk("no_bubble", 32'(dif.out_valid), 32'd1);
        chk("stream_in_ready", 32'(dif.in_ready), 32'd1);
      end
      if (dif.in_valid && dif.in_ready) sb.push_back(cur_exp);
      if (dif.out_valid && dif.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("pop y=%h all=%b any=%b exp y=%h all=%b any=%b", dif.y, dif.y_all, dif.y_any, e[5:2], e[1], e[0]);
          chk("y", 32'(dif.y), 32'(e[5:2]));
          chk("y_all", 32'(dif.y_all), 32'(e[1]));
          chk("y_any", 32'(dif.y_any), 32'(e[0]));
        end
        exp_count = exp_count + 8'd1;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [5:0] exp);
    logic acc;
    int   n;
    dif.a = a; dif.b = b; dif.op = op; dif.in_valid = 1'b1; cur_exp = exp;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = dif.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    dif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    dif.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    dif.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [3:0] tab [8];

  initial begin
    tab = '{4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001, 4'b1100, 4'b0011};
    dif.a = '0; dif.b = '0; dif.op = '0; dif.in_valid = 1'b0; dif.out_ready = 1'b0;
    wif.a = 4'h5; wif.b = '0; wif.op = 3'd7; wif.in_valid = 1'b0; wif.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_y", 32'(dif.y), 32'd0);
    chk("rst_y_all", 32'(dif.y_all), 32'd0);
    chk("rst_y_any", 32'(dif.y_any), 32'd0);
    chk("rst_op_count", 32'(dif.op_count), 32'd0);

    // All eight gates on a=0011, b=0101
    dif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] t;
      t = tab[i];
      send(4'b0011, 4'b0101, 3'(i), {t, &t, |t});
    end
    drain();
    chk("count_after_gates", 32'(dif.op_count), 32'd8);

    send(4'hF, 4'hF, 3'd0, {4'hF, 1'b1, 1'b1});
    send(4'hF, 4'h0, 3'd0, {4'h0, 1'b0, 1'b0});
    drain();

    // Backpressure: third operation must be held until the consumer drains
    do_reset();
    dif.out_ready = 1'b0;
    send(4'd1, 4'd2, 3'd2, {4'h3, 1'b0, 1'b1});
    send(4'd3, 4'd1, 3'd2, {4'h2, 1'b0, 1'b1});
    chk("full_in_ready", 32'(dif.in_ready), 32'd0);
    chk("full_out_valid", 32'(dif.out_valid), 32'd1);
    fork
      send(4'd4, 4'd8, 3'd1, {4'hC, 1'b0, 1'b1});
      begin
        repeat (3) begin
          @(negedge clk);
          chk("held_in_ready", 32'(dif.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
      end
    join
    drain();
    chk("count_after_bp", 32'(dif.op_count), 32'd3);

    // Streaming with simultaneous accept+pop
    do_reset();
    dif.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7));
      send(a, b, op, gate_model(a, b, op));
      stream_chk = 1'b1;
    end
    stream_chk = 1'b0;
    drain();
    chk("count_after_stream", 32'(dif.op_count), 32'd10);

    // Asynchronous reset while FULL
    do_reset();
    for (int i = 0; i < 5; i++) send(4'(i), 4'hA, 3'd1, gate_model(4'(i), 4'hA, 3'd1));
    drain();
    dif.out_ready = 1'b0;
    send(4'h6, 4'h3, 3'd0, {4'h2, 1'b0, 1'b1});
    send(4'h6, 4'h3, 3'd1, {4'h7, 1'b0, 1'b1});
    chk("pre_rst_in_ready", 32'(dif.in_ready), 32'd0);
    chk("pre_rst_count", 32'(dif.op_count), 32'd5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(dif.out_valid), 32'd0);
    chk("async_in_ready", 32'(dif.in_ready), 32'd1);
    chk("async_op_count", 32'(dif.op_count), 32'd0);
    chk("async_y", 32'(dif.y), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dif.out_ready = 1'b1;
    send(4'hA, 4'h5, 3'd2, {4'hF, 1'b1, 1'b1});
    chk("post_rst_out_valid", 32'(dif.out_valid), 32'd1);
    chk("post_rst_y", 32'(dif.y), 32'hF);
    drain();

    // Counter wrap on the 2-bit instance
    fork
      begin
        @(posedge clk);
        #1 wif.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 wif.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          int n;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!(wif.out_valid && wif.out_ready) && n < 20);
          @(posedge clk);
          #1;
          chk("wrap_count", 32'(wif.op_count), 32'((i + 1) % 4));
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
